uart_tx: RTL and testbench

UART transmit path: serialises one 8-bit byte per request into a start bit, 8 data bits sent LSB first, an optional even-parity bit and 1 or 2 stop bits. Bit timing comes from an internal clock divider. The parity bit equals the XOR of the 8 data bits, which is the value the receive-side parity checker expects on the wire. The block sits between the host-side transmit interface and the serial `tx` pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_counter.sv | 30 +++
 rtl/uart_tx.sv | 124 ++++++++++++
 tb/tb_uart_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit FSM state encoding and the
// parity helper also used by the receive path.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Wire parity bit: XOR of the data bits.
  function automatic logic calc_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at zero while clear is high.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Free-running bit-period counter, wrapping at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// 1 or 2 stop bits. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_en,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic       LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [2:0] LAST_IDX  = 3'(DATA_W - 1);

  uart_tx_state_t    state_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_en_r;
  logic              par_bit_r;
  logic [2:0]        bit_idx_r;
  logic              stop_cnt_r;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              clear_s;
  logic              bit_tick_s;

  // Counter sits at zero in IDLE so the start bit gets a full period.
  assign clear_s = (state_r == IDLE);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .bit_tick (bit_tick_s)
  );

  // Frame sequencer; tx is loaded one cycle ahead of each bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tx_start) begin
            shift_r    <= tx_data;
            par_en_r   <= parity_en;
            par_bit_r  <= calc_parity(tx_data);
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= START;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (bit_tick_s) begin
            tx_r    <= shift_r[0];
            state_r <= DATA;
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            if (bit_idx_r == LAST_IDX) begin
              bit_idx_r <= 3'd0;
              tx_r      <= par_en_r ? par_bit_r : 1'b1;
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              tx_r      <= shift_r[1];
              shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_tick_s) begin
            tx_r    <= 1'b1;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (bit_tick_s) begin
            if (stop_cnt_r == LAST_STOP) begin
              stop_cnt_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx with one-stop and two-stop instances.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int C = 4;

  typedef struct {
    int         n;
    logic [7:0] data;
    bit         par;
    int         abort;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st1 = 1'b0, st2 = 1'b0;
  logic [7:0] dt1 = 8'h00, dt2 = 8'h00;
  logic       pe1 = 1'b0, pe2 = 1'b0;
  logic       tx1, busy1, done1, tx2, busy2, done2;

  int     cyc = 0;
  bit     mon_on = 1'b0;
  int     compared = 0;
  int     mismatched = 0;
  frame_t sb1[$];
  frame_t sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_start(st1), .tx_data(dt1), .parity_en(pe1),
    .tx(tx1), .tx_busy(busy1), .tx_done(done1));

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(st2), .tx_data(dt2), .parity_en(pe2),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  function automatic int flen(input bit par, input int stop);
    return C * (1 + 8 + int'(par) + stop);
  endfunction

  // Expected {tx, busy, done} in spec cycle k for a frame accepted at the end of cycle f.n.
  function automatic logic [2:0] exp_out(input frame_t f, input int k, input int stop);
    int   fl;
    int   b;
    logic v;
    fl = flen(f.par, stop);
    if (k >= f.abort || k <= f.n) return 3'b100;
    if (k <= f.n + fl) begin
      b = (k - f.n - 1) / C;
      if (b == 0)                 v = 1'b0;
      else if (b <= 8)            v = f.data[b-1];
      else if (f.par && b == 9)   v = ^f.data;
      else                        v = 1'b1;
      return {v, 1'b1, 1'b0};
    end
    if (k == f.n + fl + 1) return 3'b101;
    return 3'b100;
  endfunction

  function automatic int fend(input frame_t f, input int stop);
    int e;
    e = f.n + flen(f.par, stop) + 2;
    return (f.abort < e) ? f.abort : e;
  endfunction

  task automatic check(input int d, input logic t, input logic b, input logic dn);
    logic [2:0] e;
    e = 3'b100;
    if (d == 0) begin
      while (sb1.size() > 0 && cyc >= fend(sb1[0], 1)) void'(sb1.pop_front());
      if (sb1.size() > 0) e = exp_out(sb1[0], cyc, 1);
    end else begin
      while (sb2.size() > 0 && cyc >= fend(sb2[0], 2)) void'(sb2.pop_front());
      if (sb2.size() > 0) e = exp_out(sb2[0], cyc, 2);
    end
    compared++;
    if ({t, b, dn} !== e) begin
      mismatched++;
      $display("FAIL dut%0d_outputs cycle %0d: {tx,busy,done} got %b want %b", d + 1, cyc, {t, b, dn}, e);
    end
  endtask

  // Monitor: compares both instances against the scoreboard every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      check(0, tx1, busy1, done1);
      check(1, tx2, busy2, done2);
    end
  end

  task automatic drive(input int d, input logic s, input logic [7:0] dv, input logic p);
    if (d == 0) begin st1 = s; dt1 = dv; pe1 = p; end
    else        begin st2 = s; dt2 = dv; pe2 = p; end
  endtask

  task automatic push(input int d, input int n, input logic [7:0] dv, input logic p);
    frame_t f;
    f.n = n; f.data = dv; f.par = p; f.abort = 1 << 30;
    if (d == 0) sb1.push_back(f);
    else        sb2.push_back(f);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One-cycle request; inputs are scrambled afterwards to prove capture.
  task automatic send(input int d, input logic [7:0] dv, input logic p, output int n);
    drive(d, 1'b1, dv, p);
    n = cyc;
    push(d, n, dv, p);
    @(negedge clk);
    drive(d, 1'b0, 8'($urandom), 1'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     n;
    int     n0;
    int     d;
    frame_t f;
    logic [7:0] dv;
    logic   p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (20) @(negedge clk);

    send(0, 8'hA5, 1'b1, n); wait_cyc(n + flen(1'b1, 1) + 1);
    send(0, 8'h07, 1'b1, n); wait_cyc(n + flen(1'b1, 1) + 1);
    send(0, 8'h07, 1'b0, n); wait_cyc(n + flen(1'b0, 1) + 1);

    // Two stop bits, with a request while busy that must be ignored.
    send(1, 8'hFF, 1'b0, n);
    wait_cyc(n + 10);
    drive(1, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 1'b0);
    wait_cyc(n + flen(1'b0, 2) + 1);

    // tx_start held high: three frames, one idle cycle apart.
    n0 = cyc;
    drive(0, 1'b1, 8'h55, 1'b0);
    push(0, n0, 8'h55, 1'b0);
    for (int i = 1; i < 3; i++) begin
      wait_cyc(n0 + i * (flen(1'b0, 1) + 1));
      push(0, cyc, 8'h55, 1'b0);
    end
    n = cyc;
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_cyc(n + flen(1'b0, 1) + 1);

    // Reset in the middle of the data bits abandons the frame.
    send(0, 8'h3C, 1'b1, n);
    wait_cyc(n + 15);
    rst = 1'b1;
    f = sb1[0];
    f.abort = n + 16;
    sb1[0] = f;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(0, 8'hC3, 1'b1, n); wait_cyc(n + flen(1'b1, 1) + 1);

    // Randomised frames on both instances with random gaps.
    for (int i = 0; i < 16; i++) begin
      d  = i % 2;
      dv = 8'($urandom);
      p  = 1'($urandom);
      send(d, dv, p, n);
      wait_cyc(n + flen(p, d + 1) + 1 + int'($urandom_range(0, 3)));
    end

    repeat (10) @(negedge clk);
    compared++;
    if (sb1.size() != 0 || sb2.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drained: pending got %0d/%0d want 0/0", sb1.size(), sb2.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
